// File: rtl/pwm_pkg.sv
// Shared PWM types, full-scale constant, clamp helper and sequencer state encoding.
package pwm_pkg;

    typedef logic [7:0] duty_t;

    localparam int unsigned DUTY_FULL_SCALE = 100;

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } seq_state_t;

    // min(max(value, min_duty), max_duty), unsigned 8-bit compare
    function automatic duty_t clamp_duty(input duty_t value, input duty_t min_duty,
                                         input duty_t max_duty);
        duty_t result;
        result = value;
        if (result < min_duty) result = min_duty;
        if (result > max_duty) result = max_duty;
        return result;
    endfunction

endpackage

// File: rtl/pwm_duty_sequencer_if.sv
// Request handshake and PWM duty write port of the duty sequencer.
interface pwm_duty_sequencer_if #(
    parameter int unsigned NB_OUTPUTS = 2
);
    import pwm_pkg::*;

    localparam int unsigned CH_W = $clog2(NB_OUTPUTS);

    logic            req_valid;
    logic            req_ready;
    logic [CH_W-1:0] req_channel;
    duty_t           req_target;
    logic [CH_W-1:0] duty_output;
    duty_t           duty_cycle;
    logic            duty_valid;

    modport master (
        output req_valid, req_channel, req_target,
        input  req_ready, duty_output, duty_cycle, duty_valid
    );

    modport slave (
        input  req_valid, req_channel, req_target,
        output req_ready, duty_output, duty_cycle, duty_valid
    );

endinterface

// File: rtl/pwm_tick_gen.sv
// Prescaler: DIV-cycle down-counter that runs while en=1 and emits a one-cycle tick.
module pwm_tick_gen #(
    parameter int unsigned DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam logic [23:0] RELOAD = 24'(DIV - 1);

    logic [23:0] count;

    assign tick = en && (count == '0);

    // Count down while enabled; reload on terminal count, when disabled or on reset
    always_ff @(posedge clk) begin
        if (rst || !en || tick) count <= RELOAD;
        else                    count <= count - 24'd1;
    end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Duty-cycle sequencer: immediate target writes or tick-paced ramping toward per-channel targets.
module pwm_duty_sequencer
    import pwm_pkg::*;
#(
    parameter int unsigned NB_OUTPUTS       = 2,
    parameter int unsigned RESET_DUTY_CYCLE = 50,
    parameter int unsigned MIN_DUTY         = 0,
    parameter int unsigned MAX_DUTY         = 100,
    parameter int unsigned RAMP_STEP        = 1,
    parameter int unsigned RAMP_DIV         = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ramp_en,
    pwm_duty_sequencer_if.slave   bus,
    output logic [NB_OUTPUTS-1:0] ch_done,
    output logic                  busy
);

    localparam int unsigned     CH_W       = $clog2(NB_OUTPUTS);
    localparam duty_t           RESET_DUTY = duty_t'(RESET_DUTY_CYCLE);
    localparam duty_t           MIN_D      = duty_t'(MIN_DUTY);
    localparam duty_t           MAX_D      = duty_t'(MAX_DUTY);
    localparam duty_t           STEP_D     = duty_t'(RAMP_STEP);
    localparam logic [CH_W-1:0] LAST_CH    = CH_W'(NB_OUTPUTS - 1);

    if (RAMP_DIV < NB_OUTPUTS + 2) begin : g_bad_div
        $error("RAMP_DIV must be at least NB_OUTPUTS+2");
    end
    if (MAX_DUTY > DUTY_FULL_SCALE || MIN_DUTY > MAX_DUTY) begin : g_bad_clamp
        $error("MIN_DUTY/MAX_DUTY out of range");
    end

    seq_state_t      state, state_next;
    logic [CH_W-1:0] idx, idx_next;
    logic            tick, tick_pending, start_scan;
    duty_t           current [NB_OUTPUTS];
    duty_t           target  [NB_OUTPUTS];
    duty_t           req_clamped;
    duty_t           scan_cur, scan_tgt, scan_diff, scan_step, scan_next;
    logic            accept, tgt_we, wr_en;
    logic [CH_W-1:0] wr_ch;
    duty_t           wr_val;

    pwm_tick_gen #(.DIV(RAMP_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (ramp_en),
        .tick (tick)
    );

    assign bus.req_ready = (state == ST_IDLE) && !tick_pending;
    assign accept        = bus.req_valid && bus.req_ready;
    assign req_clamped   = clamp_duty(bus.req_target, MIN_D, MAX_D);
    assign busy          = (state != ST_IDLE) || tick_pending;

    // One bounded ramp step for the channel under scan; the step never exceeds the distance left
    always_comb begin
        scan_cur  = current[idx];
        scan_tgt  = target[idx];
        scan_diff = (scan_tgt > scan_cur) ? scan_tgt - scan_cur : scan_cur - scan_tgt;
        scan_step = (scan_diff < STEP_D) ? scan_diff : STEP_D;
        scan_next = (scan_tgt > scan_cur) ? scan_cur + scan_step : scan_cur - scan_step;
    end

    // Next state, scan index and write decision
    always_comb begin
        state_next = state;
        idx_next   = idx;
        start_scan = 1'b0;
        tgt_we     = 1'b0;
        wr_en      = 1'b0;
        wr_ch      = idx;
        wr_val     = scan_next;
        unique case (state)
            ST_IDLE: begin
                if (tick_pending) begin
                    start_scan = 1'b1;
                    idx_next   = '0;
                    state_next = ST_SCAN;
                end else if (accept) begin
                    tgt_we = 1'b1;
                    if (!ramp_en) begin
                        wr_en  = 1'b1;
                        wr_ch  = bus.req_channel;
                        wr_val = req_clamped;
                    end
                end
            end
            ST_SCAN: begin
                wr_en = (scan_cur != scan_tgt);
                if (idx == LAST_CH) state_next = ST_IDLE;
                else                idx_next   = idx + 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Pending tick: set by the prescaler, consumed when a scan starts, dropped while not ramping
    always_ff @(posedge clk) begin
        if (rst || !ramp_en) tick_pending <= 1'b0;
        else if (tick)       tick_pending <= 1'b1;
        else if (start_scan) tick_pending <= 1'b0;
    end

    // Per-channel current and target duty
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NB_OUTPUTS; i++) begin
                current[i] <= RESET_DUTY;
                target[i]  <= RESET_DUTY;
            end
        end else begin
            if (tgt_we) target[bus.req_channel] <= req_clamped;
            if (wr_en)  current[wr_ch]          <= wr_val;
        end
    end

    // Registered PWM write port; the strobe lasts one cycle per write
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.duty_valid  <= 1'b0;
            bus.duty_output <= '0;
            bus.duty_cycle  <= RESET_DUTY;
        end else begin
            bus.duty_valid <= wr_en;
            if (wr_en) begin
                bus.duty_output <= wr_ch;
                bus.duty_cycle  <= wr_val;
            end
        end
    end

    // Channel settled flags
    always_comb begin
        ch_done = '0;
        for (int unsigned i = 0; i < NB_OUTPUTS; i++) ch_done[i] = (current[i] == target[i]);
    end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Self-checking bench for pwm_duty_sequencer against a transaction-level reference model.
module tb_pwm_duty_sequencer;
    import pwm_pkg::*;

    localparam int NB     = 2;
    localparam int CW     = $clog2(NB);
    localparam int RST_D  = 50;
    localparam int MIN_D  = 10;
    localparam int MAX_D  = 90;
    localparam int STEP   = 2;
    localparam int DIV    = 8;
    localparam int VW     = 1 + CW + 8 + NB + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          ramp_en;
    logic [NB-1:0] ch_done;
    logic          busy;

    pwm_duty_sequencer_if #(.NB_OUTPUTS(NB)) bus ();

    pwm_duty_sequencer #(
        .NB_OUTPUTS       (NB),
        .RESET_DUTY_CYCLE (RST_D),
        .MIN_DUTY         (MIN_D),
        .MAX_DUTY         (MAX_D),
        .RAMP_STEP        (STEP),
        .RAMP_DIV         (DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ramp_en (ramp_en),
        .bus     (bus),
        .ch_done (ch_done),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: duty arrays, cycles since last tick, pending tick and remaining scan channels
    int m_cur [NB];
    int m_tgt [NB];
    int m_since;
    bit m_pend;
    int scan_q [$];
    bit m_valid;
    int m_out;
    int m_cycle;

    function automatic bit m_ready();
        return (scan_q.size() == 0) && !m_pend;
    endfunction

    function automatic logic [NB-1:0] m_done();
        logic [NB-1:0] d;
        d = '0;
        for (int i = 0; i < NB; i++) d[i] = (m_cur[i] == m_tgt[i]);
        return d;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {m_valid, CW'(m_out), 8'(m_cycle), m_done(), (scan_q.size() != 0) || m_pend};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {bus.duty_valid, bus.duty_output, bus.duty_cycle, ch_done, busy};
    endfunction

    task automatic drive(input bit v, input int ch, input int t);
        bus.req_valid   = v;
        bus.req_channel = CW'(ch);
        bus.req_target  = 8'(t);
    endtask

    // Clock one edge and apply the same edge to the model, then settle past the edge
    task automatic advance();
        bit v, en, r, consumed;
        int ch, t, c, d, s;
        v  = bus.req_valid;
        en = ramp_en;
        r  = rst;
        ch = int'(bus.req_channel);
        t  = int'(bus.req_target);
        @(posedge clk);
        m_valid  = 1'b0;
        consumed = 1'b0;
        if (r) begin
            for (int i = 0; i < NB; i++) begin
                m_cur[i] = RST_D;
                m_tgt[i] = RST_D;
            end
            m_since = 0;
            m_pend  = 1'b0;
            scan_q.delete();
            m_out   = 0;
            m_cycle = RST_D;
        end else begin
            if (scan_q.size() > 0) begin
                ch = scan_q.pop_front();
                if (m_cur[ch] != m_tgt[ch]) begin
                    d = (m_tgt[ch] > m_cur[ch]) ? m_tgt[ch] - m_cur[ch] : m_cur[ch] - m_tgt[ch];
                    s = (d < STEP) ? d : STEP;
                    m_cur[ch] = (m_tgt[ch] > m_cur[ch]) ? m_cur[ch] + s : m_cur[ch] - s;
                    m_valid = 1'b1;
                    m_out   = ch;
                    m_cycle = m_cur[ch];
                end
            end else if (m_pend) begin
                for (int i = 0; i < NB; i++) scan_q.push_back(i);
                consumed = 1'b1;
            end else if (v) begin
                c = (t < MIN_D) ? MIN_D : ((t > MAX_D) ? MAX_D : t);
                m_tgt[ch] = c;
                if (!en) begin
                    m_cur[ch] = c;
                    m_valid = 1'b1;
                    m_out   = ch;
                    m_cycle = c;
                end
            end
            if (!en) begin
                m_since = 0;
                m_pend  = 1'b0;
            end else if (m_since == DIV - 1) begin
                m_since = 0;
                m_pend  = 1'b1;
            end else begin
                m_since++;
                if (consumed) m_pend = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ramp_en = 1'b0;
        drive(0, 0, 0);
        advance();
        advance();
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_model: got %h expected %h", obs_vec(), exp_vec());
        end
        checks++;
        if ({bus.duty_valid, bus.duty_output, bus.duty_cycle, ch_done, busy, bus.req_ready}
            !== {1'b0, CW'(0), 8'd50, 2'b11, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_values: got v=%b o=%0d c=%0d done=%b busy=%b rdy=%b expected 0/0/50/11/0/1",
                     bus.duty_valid, bus.duty_output, bus.duty_cycle, ch_done, busy, bus.req_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_immediate();
        ramp_en = 1'b0;
        drive(1, 1, 30);
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL imm_ready: got %b expected 1", bus.req_ready);
        end
        advance();
        drive(0, 0, 0);
        checks++;
        if ({bus.duty_valid, bus.duty_output, bus.duty_cycle, ch_done} !== {1'b1, CW'(1), 8'd30, 2'b11}) begin
            errors++;
            $display("FAIL imm_write: got v=%b o=%0d c=%0d done=%b expected 1/1/30/11",
                     bus.duty_valid, bus.duty_output, bus.duty_cycle, ch_done);
        end
        // back-to-back random immediate writes, one per cycle
        for (int k = 0; k < 24; k++) begin
            drive($urandom_range(0, 1) == 0, int'($urandom_range(0, NB - 1)), int'($urandom_range(0, 255)));
            #1;
            checks++;
            if (bus.req_ready !== m_ready()) begin
                errors++;
                $display("FAIL imm_rand_ready: got %b expected %b", bus.req_ready, m_ready());
            end
            advance();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL imm_rand_out: got %h expected %h", obs_vec(), exp_vec());
            end
        end
        drive(0, 0, 0);
    endtask

    task automatic test_clamp();
        int tv [2];
        int ev [2];
        tv[0] = 5;   ev[0] = 10;
        tv[1] = 200; ev[1] = 90;
        ramp_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(1, k, tv[k]);
            advance();
            checks++;
            if ({bus.duty_valid, bus.duty_output, bus.duty_cycle} !== {1'b1, CW'(k), 8'(ev[k])}) begin
                errors++;
                $display("FAIL clamp_%0d: got v=%b o=%0d c=%0d expected 1/%0d/%0d",
                         tv[k], bus.duty_valid, bus.duty_output, bus.duty_cycle, k, ev[k]);
            end
        end
        drive(0, 0, 0);
        advance();
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL clamp_idle: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_ramp();
        int w_ch [$];
        int w_val [$];
        int w_at [$];
        bit w_done [$];
        rst = 1'b1;
        advance();
        rst = 1'b0;
        ramp_en = 1'b1;
        drive(1, 0, 55);
        for (int n = 0; n < 40; n++) begin
            #1;
            checks++;
            if (bus.req_ready !== m_ready()) begin
                errors++;
                $display("FAIL ramp_ready: got %b expected %b", bus.req_ready, m_ready());
            end
            advance();
            drive(0, 0, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL ramp_out: got %h expected %h", obs_vec(), exp_vec());
            end
            if (bus.duty_valid === 1'b1) begin
                w_ch.push_back(int'(bus.duty_output));
                w_val.push_back(int'(bus.duty_cycle));
                w_at.push_back(n);
                w_done.push_back(ch_done[0]);
            end
        end
        checks++;
        if (w_val.size() != 3) begin
            errors++;
            $display("FAIL ramp_count: got %0d writes expected 3", w_val.size());
        end else begin
            checks++;
            if (w_ch[0] != 0 || w_ch[1] != 0 || w_ch[2] != 0 ||
                w_val[0] != 52 || w_val[1] != 54 || w_val[2] != 55) begin
                errors++;
                $display("FAIL ramp_values: got ch%0d=%0d ch%0d=%0d ch%0d=%0d expected ch0 52,54,55",
                         w_ch[0], w_val[0], w_ch[1], w_val[1], w_ch[2], w_val[2]);
            end
            checks++;
            if (w_at[1] - w_at[0] != DIV || w_at[2] - w_at[1] != DIV) begin
                errors++;
                $display("FAIL ramp_spacing: got %0d,%0d expected %0d", w_at[1] - w_at[0], w_at[2] - w_at[1], DIV);
            end
            checks++;
            if ({w_done[0], w_done[1], w_done[2]} !== 3'b001) begin
                errors++;
                $display("FAIL ramp_done: got %b%b%b expected 001", w_done[0], w_done[1], w_done[2]);
            end
        end
    endtask

    task automatic test_overshoot();
        int nw;
        int lv;
        bit accepted;
        nw = 0;
        lv = -1;
        accepted = 1'b0;
        drive(1, 1, 49);
        for (int n = 0; n < 4 * DIV; n++) begin
            #1;
            checks++;
            if (bus.req_ready !== m_ready()) begin
                errors++;
                $display("FAIL over_ready: got %b expected %b", bus.req_ready, m_ready());
            end
            if (m_ready()) accepted = 1'b1;
            advance();
            if (accepted) drive(0, 0, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL over_out: got %h expected %h", obs_vec(), exp_vec());
            end
            if (bus.duty_valid === 1'b1) begin
                nw++;
                lv = int'(bus.duty_cycle);
            end
        end
        checks++;
        if (nw != 1 || lv != 49) begin
            errors++;
            $display("FAIL over_single: got %0d writes last %0d expected 1 write of 49", nw, lv);
        end
    endtask

    task automatic test_collision();
        int lows;
        bit got;
        drive(0, 0, 0);
        for (int n = 0; n < 2 * DIV && !(m_pend && scan_q.size() == 0); n++) begin
            advance();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL coll_pre: got %h expected %h", obs_vec(), exp_vec());
            end
        end
        lows = 0;
        got = 1'b0;
        drive(1, 1, 70);
        for (int n = 0; n < 10 && !got; n++) begin
            #1;
            checks++;
            if (bus.req_ready !== m_ready()) begin
                errors++;
                $display("FAIL coll_ready: got %b expected %b", bus.req_ready, m_ready());
            end
            if (bus.req_ready === 1'b1) got = 1'b1;
            else lows++;
            advance();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL coll_out: got %h expected %h", obs_vec(), exp_vec());
            end
        end
        drive(0, 0, 0);
        checks++;
        if (!got || lows != NB + 1) begin
            errors++;
            $display("FAIL coll_wait: got accepted=%b after %0d stalled cycles expected 1 after %0d",
                     got, lows, NB + 1);
        end
    endtask

    task automatic test_reset_mid_scan();
        int nw;
        drive(1, 0, 20);
        for (int n = 0; n < 4 * DIV && !(scan_q.size() == 1); n++) begin
            #1;
            if (m_ready()) begin
                advance();
                drive(0, 0, 0);
            end else begin
                advance();
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL mid_pre: got %h expected %h", obs_vec(), exp_vec());
            end
        end
        drive(0, 0, 0);
        checks++;
        if (scan_q.size() != 1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_reach: got busy=%b scan_left=%0d expected 1/1", busy, scan_q.size());
        end
        rst = 1'b1;
        advance();
        rst = 1'b0;
        checks++;
        if ({bus.duty_valid, bus.duty_cycle, ch_done, busy} !== {1'b0, 8'd50, 2'b11, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: got v=%b c=%0d done=%b busy=%b expected 0/50/11/0",
                     bus.duty_valid, bus.duty_cycle, ch_done, busy);
        end
        nw = 0;
        for (int n = 0; n < 3 * DIV; n++) begin
            advance();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL mid_after: got %h expected %h", obs_vec(), exp_vec());
            end
            if (bus.duty_valid === 1'b1) nw++;
        end
        checks++;
        if (nw != 0) begin
            errors++;
            $display("FAIL mid_quiet: got %0d writes expected 0", nw);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 49) == 0) ramp_en = ~ramp_en;
            rst = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 2) == 0, int'($urandom_range(0, NB - 1)), int'($urandom_range(0, 255)));
            #1;
            checks++;
            if (bus.req_ready !== m_ready()) begin
                errors++;
                $display("FAIL rand_ready: got %b expected %b", bus.req_ready, m_ready());
            end
            advance();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rand_out: got %h expected %h", obs_vec(), exp_vec());
            end
        end
        rst = 1'b0;
        drive(0, 0, 0);
    endtask

    initial begin
        m_since = 0;
        m_pend  = 1'b0;
        m_valid = 1'b0;
        m_out   = 0;
        m_cycle = RST_D;
        for (int i = 0; i < NB; i++) begin
            m_cur[i] = RST_D;
            m_tgt[i] = RST_D;
        end
        rst = 1'b1;
        ramp_en = 1'b0;
        drive(0, 0, 0);
        #1;
        test_reset();
        test_immediate();
        test_clamp();
        test_ramp();
        test_overshoot();
        test_collision();
        test_reset_mid_scan();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_duty_sequencer.md
Name: pwm_duty_sequencer

Overview:
Controller in front of the multi-output PWM block's single duty-cycle write port (channel select, duty value, valid strobe). Holds a per-channel current and target duty. Accepts target requests over a valid/ready handshake. Either writes a new target immediately or ramps every channel toward its target in bounded steps on a periodic tick, sequencing one write per cycle to the PWM.

Parameters:
NB_OUTPUTS, 2, number of PWM channels (>= 2)
RESET_DUTY_CYCLE, 50, current/target value of every channel after reset (%)
MIN_DUTY, 0, lower clamp for targets (%)
MAX_DUTY, 100, upper clamp for targets (%)
RAMP_STEP, 1, max duty change per channel per ramp tick (1..100)
RAMP_DIV, 100000, clock cycles between ramp ticks (24-bit; elaboration error if < NB_OUTPUTS+2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ramp_en  in  1  1: ramp mode, 0: immediate mode
req_valid  in  1  target request valid
req_ready  out  1  request accepted when valid&ready
req_channel  in  $clog2(NB_OUTPUTS)  channel of request
req_target  in  8  requested duty (%)
duty_output  out  $clog2(NB_OUTPUTS)  to PWM duty_output
duty_cycle  out  8  to PWM duty_cycle
duty_valid  out  1  to PWM duty_valid, one-cycle strobe
ch_done  out  NB_OUTPUTS  bit i = (current[i] == target[i])
busy  out  1  state != IDLE or tick_pending

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst.
- Reset values:
  - current[i] = target[i] = RESET_DUTY_CYCLE.
  - duty_valid=0, duty_output=0, duty_cycle=RESET_DUTY_CYCLE.
  - State IDLE, tick_pending=0, tick counter=RAMP_DIV-1, ch_done all 1, busy=0.
- Reset mid-scan aborts the scan with no further writes.
- duty_output, duty_cycle and duty_valid are registers. duty_valid is high for exactly one cycle per write.
- Clamp: clamped = min(max(req_target, MIN_DUTY), MAX_DUTY). Unsigned 8-bit compare.
- Tick counter:
  - Counts down only while ramp_en=1. On 0, reloads RAMP_DIV-1 and sets tick_pending.
  - While ramp_en=0 the counter is held at RAMP_DIV-1 and tick_pending is cleared.
- req_ready = (state==IDLE) && !tick_pending. This is combinational; a pending tick has priority over requests.
- FSM states: IDLE, SCAN.
  - IDLE, request accepted, ramp_en=0:
    - target[ch] and current[ch] <= clamped.
    - Next cycle: duty_valid=1, duty_output=ch, duty_cycle=clamped.
    - Stay in IDLE. Throughput is one request per cycle.
  - IDLE, request accepted, ramp_en=1:
    - target[ch] <= clamped only. No write.
  - IDLE with tick_pending:
    - Clear tick_pending, idx <= 0, go to SCAN.
  - SCAN, one channel per cycle, channel idx:
    - If current != target: d = |target - current|, s = min(RAMP_STEP, d), next = current ± s toward target (never overshoots).
    - current[idx] <= next. Next cycle: duty_valid=1, duty_output=idx, duty_cycle=next.
    - If equal: no write.
    - idx == NB_OUTPUTS-1 → IDLE, otherwise idx+1.
    - A scan lasts exactly NB_OUTPUTS cycles.
- A tick arriving during SCAN is latched in tick_pending and served after return to IDLE.
- ramp_en falling during SCAN: the scan completes, and later requests are immediate.
- Channels left mid-ramp stay at their current value until a new request arrives or ramp_en returns to 1.

Decomposition:
- Package pwm_pkg:
  - typedef duty_t (logic [7:0]).
  - localparam DUTY_FULL_SCALE=100.
  - function clamp_duty(value, min, max).
  - These are shared with the PWM block.
- One sub-module: pwm_tick_gen (RAMP_DIV down-counter with enable, one-cycle tick output). It is reusable for other prescaled timers.

Test Plan:
- Immediate write:
  - ramp_en=0; valid ch1 target 30.
  - Expect req_ready=1; next cycle duty_valid=1, duty_output=1, duty_cycle=30; ch_done=2'b11.
- Clamp (MIN_DUTY=10, MAX_DUTY=90):
  - Target 5 → duty_cycle 10.
  - Target 200 → duty_cycle 90.
- Ramp (RAMP_DIV=8, RAMP_STEP=1, ramp_en=1):
  - ch0 target 53.
  - Expect writes of 51, 52, 53 on ch0, one per tick, 8 cycles apart; no ch1 writes; ch_done[0] rises after the third write.
- Overshoot guard (RAMP_STEP=5):
  - ch1 from 50 to target 48.
  - Expect a single write of 48; no write on the next tick.
- Collision:
  - Assert req_valid in the same cycle tick_pending sets.
  - Expect req_ready=0 through SCAN (NB_OUTPUTS cycles), then the request is accepted in IDLE.
- Reset mid-scan:
  - Assert rst during SCAN idx=1.
  - Expect duty_valid=0 the next cycle, all channels back to 50, busy=0, and no writes until a new request.
